// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: owns the PC, reads a synchronous instruction RAM
// and hands one instruction at a time to the pipeline controller.
//
// state      | meaning
// RESET_S    | one idle cycle after reset; PC may be redirected here
// FETCH      | imem_addr presents pc to the RAM
// FETCH_WAIT | RAM data valid; captured into instr_out at the edge
// DELIVER    | instr_out valid; held while stall is high
module instr_fetch_unit #(
  parameter int          ADDR_W    = 11,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'hE1A0_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_pc,
  input  logic [31:0]       pc_target,
  input  logic              stall,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       instr_out,
  output logic              instr_valid,
  output logic [31:0]       pc_out,
  output logic [31:0]       pc_plus8,
  output logic [31:0]       fetch_count
);

  typedef enum logic [1:0] {
    RESET_S    = 2'd0,
    FETCH      = 2'd1,
    FETCH_WAIT = 2'd2,
    DELIVER    = 2'd3
  } state_t;

  state_t      state, state_next;
  logic [31:0] pc, pc_next;
  logic        capture;
  logic        consume;

  assign imem_addr = pc[ADDR_W+1:2];
  assign pc_plus8  = pc_out + 32'd8;

  always_comb begin
    state_next = state;
    pc_next    = pc;
    capture    = 1'b0;
    consume    = 1'b0;
    // A redirect pre-empts whatever the FSM was doing, including a held delivery.
    if (load_pc) begin
      state_next = FETCH;
      pc_next    = pc_target & 32'hFFFF_FFFC;
    end else begin
      case (state)
        RESET_S:    state_next = FETCH;
        FETCH:      state_next = FETCH_WAIT;
        FETCH_WAIT: begin
          state_next = DELIVER;
          capture    = 1'b1;
        end
        DELIVER: begin
          if (!stall) begin
            state_next = FETCH;
            pc_next    = pc + 32'd4;
            consume    = 1'b1;
          end
        end
        default:    state_next = RESET_S;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RESET_S;
      pc          <= RESET_PC;
      instr_out   <= NOP_INSTR;
      pc_out      <= RESET_PC;
      instr_valid <= 1'b0;
      fetch_count <= 32'd0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      if (capture) begin
        instr_out   <= imem_rdata;
        pc_out      <= pc;
        instr_valid <= 1'b1;
      end else if (load_pc || consume) begin
        instr_valid <= 1'b0;
      end
      if (consume) fetch_count <= fetch_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus random redirect/stall/reset
// traffic, compared every cycle against a delivery-countdown reference model.
module tb_instr_fetch_unit;

  localparam int          AW  = 11;
  localparam logic [31:0] NOP = 32'hE1A0_0000;

  logic          clk = 1'b0;
  logic          rst, load_pc, stall;
  logic [31:0]   pc_target;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_rdata, instr_out, pc_out, pc_plus8, fetch_count;
  logic          instr_valid;

  logic          w_load = 1'b0, w_stall = 1'b0;
  logic [31:0]   w_target = 32'd0;
  logic [AW-1:0] w_imem_addr;
  logic [31:0]   w_rdata, w_instr, w_pc_out, w_pc_plus8, w_count;
  logic          w_valid;

  logic [31:0] mem [0:(1<<AW)-1];

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [31:0] m_pc, m_instr, m_pcout, m_cnt;
  logic        m_valid;
  int          m_wait;

  always #5 clk = ~clk;

  always @(posedge clk) imem_rdata <= mem[imem_addr];
  always @(posedge clk) w_rdata    <= mem[w_imem_addr];

  instr_fetch_unit #(.ADDR_W(AW), .RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) u_dut (
    .clk(clk), .rst(rst), .load_pc(load_pc), .pc_target(pc_target), .stall(stall),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata), .instr_out(instr_out),
    .instr_valid(instr_valid), .pc_out(pc_out), .pc_plus8(pc_plus8),
    .fetch_count(fetch_count)
  );

  instr_fetch_unit #(.ADDR_W(AW), .RESET_PC(32'hFFFF_FFFC), .NOP_INSTR(NOP)) u_dut_wrap (
    .clk(clk), .rst(rst), .load_pc(w_load), .pc_target(w_target), .stall(w_stall),
    .imem_addr(w_imem_addr), .imem_rdata(w_rdata), .instr_out(w_instr),
    .instr_valid(w_valid), .pc_out(w_pc_out), .pc_plus8(w_pc_plus8),
    .fetch_count(w_count)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock: drive inputs at negedge, advance model at posedge, compare at next negedge.
  // The model counts edges until the next delivery instead of tracking FSM states.
  task automatic step(input logic r, input logic l, input logic [31:0] t, input logic s);
    rst = r; load_pc = l; pc_target = t; stall = s;
    @(posedge clk);
    if (r) begin
      m_pc = 32'h0; m_wait = 3; m_valid = 1'b0; m_instr = NOP; m_pcout = 32'h0; m_cnt = 0;
    end else if (l) begin
      m_pc = {t[31:2], 2'b00}; m_wait = 2; m_valid = 1'b0;
    end else if (m_valid) begin
      if (!s) begin
        m_pc = m_pc + 4; m_cnt = m_cnt + 1; m_valid = 1'b0; m_wait = 2;
      end
    end else begin
      m_wait--;
      if (m_wait == 0) begin
        m_valid = 1'b1; m_instr = mem[m_pc[AW+1:2]]; m_pcout = m_pc;
      end
    end
    @(negedge clk);
    check_eq("valid",     {31'd0, instr_valid}, {31'd0, m_valid});
    check_eq("instr",     instr_out,   m_instr);
    check_eq("pc_out",    pc_out,      m_pcout);
    check_eq("pc_plus8",  pc_plus8,    m_pcout + 32'd8);
    check_eq("count",     fetch_count, m_cnt);
    check_eq("imem_addr", {{(32-AW){1'b0}}, imem_addr}, {{(32-AW){1'b0}}, m_pc[AW+1:2]});
  endtask

  initial begin
    logic [31:0] tgt;
    for (int i = 0; i < (1 << AW); i++) mem[i] = $urandom;
    mem[0] = 32'hE3A01005;
    mem[1] = 32'hE2811001;
    rst = 1'b1; load_pc = 1'b0; stall = 1'b0; pc_target = 32'd0;
    @(negedge clk);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    check_eq("rst_valid", {31'd0, instr_valid}, 32'd0);
    check_eq("rst_instr", instr_out, NOP);
    check_eq("rst_count", fetch_count, 32'd0);

    // first deliveries
    repeat (3) step(0, 0, 0, 0);
    check_eq("first_valid", {31'd0, instr_valid}, 32'd1);
    check_eq("first_instr", instr_out, 32'hE3A01005);
    check_eq("first_pc", pc_out, 32'd0);
    check_eq("first_p8", pc_plus8, 32'd8);
    check_eq("wrap_pc", w_pc_out, 32'hFFFF_FFFC);
    check_eq("wrap_addr", {21'd0, w_imem_addr}, 32'h7FF);
    check_eq("wrap_p8", w_pc_plus8, 32'd4);
    check_eq("wrap_instr", w_instr, mem[2047]);
    repeat (3) step(0, 0, 0, 0);
    check_eq("second_instr", instr_out, 32'hE2811001);
    check_eq("second_pc", pc_out, 32'd4);
    check_eq("second_count", fetch_count, 32'd1);
    check_eq("wrap_next_pc", w_pc_out, 32'd0);
    check_eq("wrap_next_instr", w_instr, mem[0]);

    // stall holds delivery of pc 4
    repeat (5) begin
      step(0, 0, 0, 1);
      check_eq("stall_valid", {31'd0, instr_valid}, 32'd1);
      check_eq("stall_pc", pc_out, 32'd4);
      check_eq("stall_addr", {21'd0, imem_addr}, 32'd1);
    end
    repeat (3) step(0, 0, 0, 0);
    check_eq("release_pc", pc_out, 32'd8);
    check_eq("release_count", fetch_count, 32'd2);

    // redirect during FETCH_WAIT with misaligned target
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 1, 32'h0000_0103, 0);
    check_eq("redir_addr", {21'd0, imem_addr}, 32'h40);
    check_eq("redir_valid", {31'd0, instr_valid}, 32'd0);
    repeat (2) step(0, 0, 0, 0);
    check_eq("redir_pc", pc_out, 32'h100);
    check_eq("redir_count", fetch_count, 32'd3);

    // redirect beats stall in DELIVER
    step(0, 1, 32'h20, 1);
    check_eq("drop_valid", {31'd0, instr_valid}, 32'd0);
    repeat (2) step(0, 0, 0, 0);
    check_eq("drop_pc", pc_out, 32'h20);

    // reset during FETCH_WAIT
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    check_eq("midrst_valid", {31'd0, instr_valid}, 32'd0);
    check_eq("midrst_instr", instr_out, NOP);
    check_eq("midrst_pc", pc_out, 32'd0);
    check_eq("midrst_count", fetch_count, 32'd0);
    repeat (3) step(0, 0, 0, 0);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      tgt = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 255);
      step($urandom_range(0, 99) == 0, $urandom_range(0, 9) == 0, tgt,
           $urandom_range(0, 2) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Instruction-side front end that supplies `instr_in` to the pipeline controller. It is the producer end of that interface and the consumer of the controller's PC redirect (`load_pc`/target).
- Owns the architectural PC and drives a synchronous-read instruction RAM (1-cycle read latency).
- Sequences FETCH -> FETCH_WAIT -> DELIVER and presents one instruction at a time with a valid flag, its PC, and the ARM-visible PC+8.
- Honours stall from the execute stage and flushes in-flight fetches on redirect.

Parameters:
- ADDR_W, 11, word-address width of instruction RAM (RAM size 4*2^ADDR_W bytes).
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- NOP_INSTR, 32'hE1A0_0000, ARM MOV r0,r0; value of instr_out after reset.

Ports:
- clk, in, 1: single clock, rising edge.
- rst, in, 1: reset. Synchronous and active-high.
- load_pc, in, 1: redirect request; sampled every cycle.
- pc_target, in, 32: byte address to load when load_pc=1.
- stall, in, 1: execute stage not ready; hold delivered instruction.
- imem_addr, out, ADDR_W: word address to instruction RAM = pc[ADDR_W+1:2] (combinational from pc register).
- imem_rdata, in, 32: RAM read data, valid the cycle after imem_addr is held.
- instr_out, out, 32: instruction to controller (instr_in).
- instr_valid, out, 1: instr_out is a fresh, deliverable instruction.
- pc_out, out, 32: byte address of instr_out.
- pc_plus8, out, 32: pc_out+8 (r15 read value), combinational.
- fetch_count, out, 32: number of instructions consumed (DELIVER exits without redirect).

Behaviour:
- States: RESET_S, FETCH, FETCH_WAIT, DELIVER.
- Reset (rst=1 at posedge, overrides all):
  - state<=RESET_S, pc<=RESET_PC, instr_out<=NOP_INSTR, pc_out<=RESET_PC, instr_valid<=0, fetch_count<=0.
  - Reset mid-fetch discards the in-flight word.
- RESET_S: instr_valid=0 -> FETCH next cycle (one-cycle PC-load slot).
- FETCH: imem_addr holds pc -> FETCH_WAIT.
- FETCH_WAIT: imem_rdata valid; at the edge instr_out<=imem_rdata, pc_out<=pc, instr_valid<=1 -> DELIVER.
- DELIVER:
  - stall=1: remain, all outputs held.
  - stall=0: pc<=pc+4, fetch_count<=fetch_count+1, instr_valid<=0 -> FETCH.
- Latency: 3 cycles per instruction unstalled. First instr_valid=1 in the 3rd cycle after rst deasserts (RESET_S, FETCH, FETCH_WAIT, then DELIVER).
- Redirect priority: rst > load_pc > stall > normal sequencing.
  - load_pc=1 in any state: pc<={pc_target[31:2],2'b00}, state<=FETCH, instr_valid<=0.
  - No fetch_count increment; instr_out and pc_out keep their old values.
  - load_pc in DELIVER with stall=1 drops the held instruction.
  - load_pc in FETCH_WAIT discards the arriving imem_rdata.
- Misaligned pc_target: bits[1:0] forced to 0, silently.
- Wrap-around:
  - pc+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 0).
  - imem_addr aliases modulo RAM size.
  - fetch_count wraps modulo 2^32.
- instr_out changes only at the FETCH_WAIT->DELIVER edge or on reset. When instr_valid=0 it is stale and must be ignored.
- No combinational path from load_pc/stall to instr_valid; all outputs except pc_plus8 and imem_addr are registered.

Test Plan:
- Reset, then RAM[0]=32'hE3A01005, RAM[1]=32'hE2811001, stall=0 -> cycle 3 after reset: instr_valid=1, instr_out=E3A01005, pc_out=0, pc_plus8=8. 3 cycles later: instr_out=E2811001, pc_out=4, fetch_count=1.
- stall=1 for 5 cycles during DELIVER of pc 4 -> instr_valid stays 1, instr_out and pc_out unchanged, imem_addr=1. On release, next delivery at pc 8, fetch_count=2.
- load_pc=1 with pc_target=32'h0000_0103 during FETCH_WAIT -> the arriving word is discarded, imem_addr=0x40 next cycle, next delivered pc_out=0x100, fetch_count unchanged.
- load_pc=1 and stall=1 in the same DELIVER cycle, target 0x20 -> instr_valid=0 next cycle, delivered pc_out=0x20 two cycles later.
- RESET_PC=32'hFFFF_FFFC, ADDR_W=11 -> first pc_out=FFFF_FFFC with imem_addr=0x7FF, next pc_out=0, pc_plus8 for the first instruction=4.
- rst=1 asserted in FETCH_WAIT -> next cycle instr_valid=0, instr_out=E1A00000, pc_out=RESET_PC, fetch_count=0, state=RESET_S.
